// File: rtl/tiny16_ioport.sv
// tiny16_ioport: CHANNELS memory-mapped I/O ports for the tiny16 core. Each port has a
// paced output FIFO, a synchronised input with sticky change detection, and feeds one IRQ.
module tiny16_ioport #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(CHANNELS) + 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [AW-1:0]             ADDR,
  input  logic [15:0]               WDATA,
  input  logic                      WE,
  input  logic                      RE,
  output logic [15:0]               RDATA,
  input  logic [CHANNELS*WIDTH-1:0] IN,
  output logic [CHANNELS*WIDTH-1:0] OUT,
  output logic [CHANNELS-1:0]       OUT_EN,
  output logic                      IRQ
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  reg_e                      reg_sel;
  logic [7:0]                ch_idx;
  logic [CHANNELS-1:0]       ch_sel;
  logic [CHANNELS-1:0][15:0] ch_rdata;
  logic [CHANNELS-1:0]       ch_irq;
  logic [15:0]               rdata_d;
  logic [15:0]               rdata_q;
  logic                      irq_q;
  logic                      unused_wdata;

  assign reg_sel      = reg_e'(ADDR[1:0]);
  assign unused_wdata = &{1'b0, WDATA[15:12]};

  if (AW > 2) begin : g_ch_idx
    assign ch_idx = 8'(ADDR[AW-1:2]);
  end else begin : g_ch_idx_one
    assign ch_idx = 8'd0;
  end

  // A channel index with no matching port selects nothing, so it reads 0 and ignores writes.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_sel
    assign ch_sel[c] = (ch_idx == 8'(c));
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       gap_q;
    logic             en_q, chg_ie_q, empty_ie_q;
    logic             ovf_q, chg_q;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] out_q;
    logic             out_en_q;
    logic             wr_data, wr_ctrl, rd_status, flush;
    logic             empty, full, pop, push, drop;
    logic [15:0]      rd_val;

    assign wr_data   = WE && ch_sel[c] && (reg_sel == REG_DATA);
    assign wr_ctrl   = WE && ch_sel[c] && (reg_sel == REG_CTRL);
    assign rd_status = RE && ch_sel[c] && (reg_sel == REG_STATUS);
    assign flush     = wr_ctrl && WDATA[11];
    assign empty     = (level_q == '0);
    assign full      = (level_q == FULL_LEVEL);

    // FLUSH wins over both ends of the FIFO; a same-edge pop frees room for a push.
    assign pop  = en_q && !empty && (pc_q == '0) && !flush;
    assign push = wr_data && !flush && (!full || pop);
    assign drop = wr_data && !flush && full && !pop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      level_d = level_q;
      pc_d    = pc_q;
      if (flush) begin
        level_d = '0;
        pc_d    = '0;
      end else begin
        level_d = level_q + LW'(push) - LW'(pop);
        if (pop)                pc_d = gap_q;
        else if (pc_q != 8'd0)  pc_d = pc_q - 8'd1;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
      if (RST) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        pc_q       <= '0;
        gap_q      <= '0;
        en_q       <= 1'b1;
        chg_ie_q   <= 1'b0;
        empty_ie_q <= 1'b0;
        ovf_q      <= 1'b0;
        chg_q      <= 1'b0;
        sync1_q    <= '0;
        sync2_q    <= '0;
        prev_q     <= '0;
        out_q      <= '0;
        out_en_q   <= 1'b0;
      end else begin
        level_q  <= level_d;
        pc_q     <= pc_d;
        out_en_q <= pop;
        if (pop) begin
          out_q    <= mem_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
        if (flush) rd_ptr_q <= wr_ptr_q;
        if (wr_ctrl) begin
          gap_q      <= WDATA[7:0];
          en_q       <= WDATA[8];
          chg_ie_q   <= WDATA[9];
          empty_ie_q <= WDATA[10];
        end
        if (drop)           ovf_q <= 1'b1;
        else if (rd_status) ovf_q <= 1'b0;
        if (sync2_q != prev_q) chg_q <= 1'b1;
        else if (rd_status)    chg_q <= 1'b0;
        sync1_q <= IN[c*WIDTH +: WIDTH];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
      end
    end

    // NOTE: FIFO storage is not reset; the pointers and level alone decide what is valid.
    always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= WDATA[WIDTH-1:0];
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        REG_DATA:   rd_val = 16'(sync2_q);
        REG_STATUS: rd_val = {1'b0, 7'(level_q), 4'b0000, chg_q, ovf_q, full, empty};
        REG_CTRL:   rd_val = {5'b00000, empty_ie_q, chg_ie_q, en_q, gap_q};
        default:    rd_val = '0;
      endcase
    end

    assign ch_rdata[c]            = rd_val;
    assign ch_irq[c]              = (chg_q && chg_ie_q) || (empty && empty_ie_q);
    assign OUT[c*WIDTH +: WIDTH]  = out_q;
    assign OUT_EN[c]              = out_en_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel[c]) rdata_d = ch_rdata[c];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (RE) rdata_q <= rdata_d;
      irq_q <= |ch_irq;
    end
  end

  assign RDATA = rdata_q;
  assign IRQ   = irq_q;
endmodule

// File: tb/tb_tiny16_ioport.sv
// Self-checking bench for tiny16_ioport: register table plus hand-written timing sequences,
// with OUT/OUT_EN traffic checked against a per-channel expected-value scoreboard.
module tb_tiny16_ioport;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 4;
  localparam int AW       = 4;

  localparam logic [AW-1:0] CH0_DATA = 4'd0;
  localparam logic [AW-1:0] CH0_STAT = 4'd1;
  localparam logic [AW-1:0] CH0_CTRL = 4'd2;
  localparam logic [AW-1:0] CH0_RSVD = 4'd3;
  localparam logic [AW-1:0] CH1_DATA = 4'd4;
  localparam logic [AW-1:0] CH1_STAT = 4'd5;
  localparam logic [AW-1:0] CH1_CTRL = 4'd6;
  localparam logic [AW-1:0] BAD_DATA = 4'd12;
  localparam logic [AW-1:0] BAD_CTRL = 4'd14;

  logic                      CLK = 1'b0;
  logic                      RST = 1'b1;
  logic [AW-1:0]             ADDR = '0;
  logic [15:0]               WDATA = '0;
  logic                      WE = 1'b0;
  logic                      RE = 1'b0;
  logic [15:0]               RDATA;
  logic [CHANNELS*WIDTH-1:0] IN = '0;
  logic [CHANNELS*WIDTH-1:0] OUT;
  logic [CHANNELS-1:0]       OUT_EN;
  logic                      IRQ;

  tiny16_ioport #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WDATA(WDATA), .WE(WE), .RE(RE), .RDATA(RDATA),
    .IN(IN), .OUT(OUT), .OUT_EN(OUT_EN), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         pulse1[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_cycle(input logic [AW-1:0] a, input logic [15:0] d,
                           input logic we, input logic re);
    ADDR  = a;
    WDATA = d;
    WE    = we;
    RE    = re;
    step();
    WE = 1'b0;
    RE = 1'b0;
  endtask

  // Scoreboard: every OUT_EN pulse must match the oldest expected value for that channel.
  always @(posedge CLK) begin
    #1;
    if (OUT_EN[0]) begin
      if (exp_q0.size() == 0) check("ch0 OUT_EN spurious", 32'(OUT_EN[0]), 32'd0);
      else                    check("ch0 OUT value", 32'(OUT[7:0]), 32'(exp_q0.pop_front()));
    end
    if (OUT_EN[1]) begin
      pulse1.push_back(cyc);
      if (exp_q1.size() == 0) check("ch1 OUT_EN spurious", 32'(OUT_EN[1]), 32'd0);
      else                    check("ch1 OUT value", 32'(OUT[15:8]), 32'(exp_q1.pop_front()));
    end
    if (OUT_EN[2]) check("ch2 OUT_EN spurious", 32'(OUT_EN[2]), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000 without finishing", $time);
    $fatal(1);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          we;
    logic          re;
    logic [15:0]   exp;
  } vec_t;

  vec_t vecs[14];
  int   k;

  initial begin
    vecs[0]  = '{CH0_CTRL, 16'h0F2A, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{CH0_CTRL, 16'h0000, 1'b0, 1'b1, 16'h072A};
    vecs[2]  = '{CH1_CTRL, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{CH1_CTRL, 16'h0000, 1'b0, 1'b1, 16'h07FF};
    vecs[4]  = '{CH0_RSVD, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{CH0_RSVD, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[6]  = '{BAD_CTRL, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{BAD_CTRL, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[8]  = '{BAD_DATA, 16'h00EE, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{CH1_CTRL, 16'h0000, 1'b0, 1'b1, 16'h07FF};
    vecs[10] = '{CH0_CTRL, 16'h0100, 1'b1, 1'b1, 16'h072A};
    vecs[11] = '{CH0_CTRL, 16'h0000, 1'b0, 1'b1, 16'h0100};
    vecs[12] = '{CH1_CTRL, 16'h0100, 1'b1, 1'b0, 16'h0000};
    vecs[13] = '{CH0_STAT, 16'h0000, 1'b0, 1'b1, 16'h0001};

    // Reset state
    repeat (2) step();
    check("reset OUT", OUT, 0);
    check("reset OUT_EN", 32'(OUT_EN), 0);
    check("reset RDATA", 32'(RDATA), 0);
    check("reset IRQ", 32'(IRQ), 0);
    RST = 1'b0;
    bus_cycle(CH0_CTRL, 16'h0, 1'b0, 1'b1);
    check("reset ch0 CTRL", 32'(RDATA), 32'h0100);
    bus_cycle(CH1_STAT, 16'h0, 1'b0, 1'b1);
    check("reset ch1 STATUS", 32'(RDATA), 32'h0001);

    // Register map, reserved register and out-of-range channel decode
    for (int i = 0; i < 14; i++) begin
      bus_cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      if (vecs[i].re) check($sformatf("vec%0d RDATA", i), 32'(RDATA), 32'(vecs[i].exp));
    end

    // Single write with GAP=0: OUT updates one edge after the write
    exp_q0.push_back(8'h5A);
    bus_cycle(CH0_DATA, 16'h005A, 1'b1, 1'b0);
    check("t1 OUT_EN at write edge", 32'(OUT_EN), 0);
    step();
    check("t1 OUT_EN pulse", 32'(OUT_EN), 32'h1);
    check("t1 OUT ch0", 32'(OUT[7:0]), 32'h5A);
    check("t1 OUT ch1 idle", 32'(OUT[15:8]), 0);
    step();
    check("t1 OUT_EN one cycle", 32'(OUT_EN), 0);
    check("t1 OUT ch0 holds", 32'(OUT[7:0]), 32'h5A);

    // GAP=3 on ch1: pops exactly 4 cycles apart
    bus_cycle(CH1_CTRL, 16'h0103, 1'b1, 1'b0);
    pulse1.delete();
    ADDR = CH1_DATA;
    WE   = 1'b1;
    WDATA = 16'h0011; exp_q1.push_back(8'h11); step(); k = cyc;
    WDATA = 16'h0022; exp_q1.push_back(8'h22); step();
    WDATA = 16'h0033; exp_q1.push_back(8'h33); step();
    WE = 1'b0;
    repeat (12) step();
    check("t2 pulse count", 32'(pulse1.size()), 3);
    if (pulse1.size() == 3) begin
      check("t2 first pulse edge", 32'(pulse1[0]), 32'(k + 1));
      check("t2 spacing 1", 32'(pulse1[1] - pulse1[0]), 4);
      check("t2 spacing 2", 32'(pulse1[2] - pulse1[1]), 4);
    end
    check("t2 ch1 drained", 32'(exp_q1.size()), 0);
    bus_cycle(CH1_CTRL, 16'h0100, 1'b1, 1'b0);

    // EN=0 overflow: fifth push dropped, OVF sticky until a STATUS read
    bus_cycle(CH0_CTRL, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q0.push_back(8'(8'hA1 + i));
      bus_cycle(CH0_DATA, 16'(8'hA1 + i), 1'b1, 1'b0);
    end
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t3 STATUS full+ovf", 32'(RDATA), 32'h0406);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t3 STATUS ovf cleared", 32'(RDATA), 32'h0402);
    bus_cycle(CH0_CTRL, 16'h0100, 1'b1, 1'b0);
    repeat (8) step();
    check("t3 ch0 drained", 32'(exp_q0.size()), 0);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t3 STATUS empty", 32'(RDATA), 32'h0001);

    // FLUSH with level=3: nothing drains, and the FIFO is reusable afterwards
    bus_cycle(CH0_CTRL, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bus_cycle(CH0_DATA, 16'(8'hC1 + i), 1'b1, 1'b0);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t4 STATUS level 3", 32'(RDATA), 32'h0300);
    bus_cycle(CH0_CTRL, 16'h0900, 1'b1, 1'b0);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t4 STATUS after flush", 32'(RDATA), 32'h0001);
    repeat (4) step();
    bus_cycle(CH0_CTRL, 16'h0, 1'b0, 1'b1);
    check("t4 CTRL flush reads 0", 32'(RDATA), 32'h0100);
    exp_q0.push_back(8'h77);
    bus_cycle(CH0_DATA, 16'h0077, 1'b1, 1'b0);
    repeat (3) step();
    check("t4 post-flush drained", 32'(exp_q0.size()), 0);

    // Input synchroniser, CHG and IRQ timing
    bus_cycle(CH0_CTRL, 16'h0300, 1'b1, 1'b0);
    IN[7:0] = 8'h81;
    step();
    bus_cycle(CH0_DATA, 16'h0, 1'b0, 1'b1);
    check("t5 DATA too early", 32'(RDATA), 32'h0000);
    bus_cycle(CH0_DATA, 16'h0, 1'b0, 1'b1);
    check("t5 DATA synced", 32'(RDATA), 32'h0081);
    check("t5 IRQ not yet", 32'(IRQ), 0);
    step();
    check("t5 IRQ set", 32'(IRQ), 1);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t5 STATUS CHG", 32'(RDATA), 32'h0009);
    check("t5 IRQ still set", 32'(IRQ), 1);
    step();
    check("t5 IRQ cleared", 32'(IRQ), 0);
    bus_cycle(CH0_STAT, 16'h0, 1'b0, 1'b1);
    check("t5 STATUS CHG cleared", 32'(RDATA), 32'h0001);

    // Empty interrupt, then reset while ch1 is mid-drain with GAP=5
    bus_cycle(CH0_CTRL, 16'h0500, 1'b1, 1'b0);
    step();
    check("t6 IRQ empty", 32'(IRQ), 1);
    bus_cycle(CH1_CTRL, 16'h0105, 1'b1, 1'b0);
    exp_q1.push_back(8'hB1);
    bus_cycle(CH1_DATA, 16'h00B1, 1'b1, 1'b0);
    bus_cycle(CH1_DATA, 16'h00B2, 1'b1, 1'b0);
    bus_cycle(CH1_DATA, 16'h00B3, 1'b1, 1'b0);
    bus_cycle(CH1_CTRL, 16'h0, 1'b0, 1'b1);
    check("t6 ch1 CTRL", 32'(RDATA), 32'h0105);
    bus_cycle(CH1_STAT, 16'h0, 1'b0, 1'b1);
    check("t6 ch1 level 2", 32'(RDATA), 32'h0200);
    check("t6 ch1 first popped", 32'(exp_q1.size()), 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6 OUT after reset", OUT, 0);
    check("t6 OUT_EN after reset", 32'(OUT_EN), 0);
    check("t6 RDATA after reset", 32'(RDATA), 0);
    check("t6 IRQ after reset", 32'(IRQ), 0);
    step();
    check("t6 no OUT_EN after reset", 32'(OUT_EN), 0);
    repeat (8) step();
    bus_cycle(CH1_CTRL, 16'h0, 1'b0, 1'b1);
    check("t6 ch1 CTRL reset", 32'(RDATA), 32'h0100);
    bus_cycle(CH1_STAT, 16'h0, 1'b0, 1'b1);
    check("t6 ch1 STATUS reset", 32'(RDATA), 32'h0001);
    bus_cycle(CH0_CTRL, 16'h0, 1'b0, 1'b1);
    check("t6 ch0 CTRL reset", 32'(RDATA), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
